chnl_sample_pipe: RTL and testbench

Parametrised multi-channel sampling pipeline: each channel registers input data through a DEPTH-stage shift pipe with per-channel enable/stall. Each channel flags value changes between consecutive valid outputs and keeps a saturating change counter. Sits between channel input sources and downstream formatter/arbiter logic as the registered capture front-end.

---
 rtl/chnl_sample_pkg.sv | 16 +
 rtl/chnl_sample_lane.sv | 116 +++++++++++
 rtl/chnl_sample_pipe.sv | 42 ++++
 tb/tb_chnl_sample_pipe.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/chnl_sample_pkg.sv
// Shared defaults and types for the multi-channel sampling pipeline.
package chnl_sample_pkg;

  localparam int CH_NUM_DEF = 4;
  localparam int DW_DEF     = 8;
  localparam int DEPTH_DEF  = 2;
  localparam int CNT_W_DEF  = 16;

  localparam logic [CNT_W_DEF-1:0] CNT_MAX_DEF = {CNT_W_DEF{1'b1}};

  typedef struct packed {
    logic              vld;
    logic [DW_DEF-1:0] data;
  } stage_t;

endpackage

// File: rtl/chnl_sample_lane.sv
// One channel: DEPTH-stage stallable capture pipe plus change history and
// saturating change counter.
module chnl_sample_lane
  import chnl_sample_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en_i,
  input  logic             in_vld_i,
  input  logic [DW-1:0]    in_data_i,
  input  logic             clr_i,
  output logic             out_vld_o,
  output logic [DW-1:0]    out_data_o,
  output logic             chg_o,
  output logic [CNT_W-1:0] chg_cnt_o
);

  localparam int               LAST    = DEPTH - 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic          vld_q  [DEPTH];
  logic          vld_d  [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [DW-1:0] data_d [DEPTH];

  logic [DW-1:0]    last_q, last_d;
  logic             seen_q, seen_d;
  logic             chg_q, chg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic load_vld_s;
  logic diff_s;

  // Pipe next state: advance on enable; on stall only the last stage drops
  // its valid so an item is never presented twice.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      vld_d[i]  = vld_q[i];
      data_d[i] = data_q[i];
    end
    if (en_i) begin
      vld_d[0]  = in_vld_i;
      data_d[0] = in_data_i;
      for (int i = 1; i < DEPTH; i++) begin
        vld_d[i]  = vld_q[i-1];
        data_d[i] = data_q[i-1];
      end
    end else begin
      vld_d[LAST] = 1'b0;
    end
  end

  assign load_vld_s = en_i & vld_d[LAST];
  assign diff_s     = (data_d[LAST] != last_q);

  // History and counter next state; clear wins over a coincident change.
  always_comb begin
    last_d = last_q;
    seen_d = seen_q;
    cnt_d  = cnt_q;
    chg_d  = 1'b0;
    if (clr_i) begin
      last_d = '0;
      seen_d = 1'b0;
      cnt_d  = '0;
    end else if (load_vld_s) begin
      last_d = data_d[LAST];
      seen_d = 1'b1;
      if (seen_q && diff_s) begin
        chg_d = 1'b1;
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end else begin
        chg_d = 1'b0;
      end
    end else begin
      chg_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        vld_q[i]  <= 1'b0;
        data_q[i] <= '0;
      end
      last_q <= '0;
      seen_q <= 1'b0;
      chg_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        vld_q[i]  <= vld_d[i];
        data_q[i] <= data_d[i];
      end
      last_q <= last_d;
      seen_q <= seen_d;
      chg_q  <= chg_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out_vld_o  = vld_q[LAST];
  assign out_data_o = data_q[LAST];
  assign chg_o      = chg_q;
  assign chg_cnt_o  = cnt_q;

endmodule

// File: rtl/chnl_sample_pipe.sv
// Multi-channel registered capture front-end: CH_NUM independent lanes
// sharing clock, reset and history clear.
module chnl_sample_pipe
  import chnl_sample_pkg::*;
#(
  parameter int CH_NUM = CH_NUM_DEF,
  parameter int DW     = DW_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [CH_NUM-1:0]       en_i,
  input  logic [CH_NUM-1:0]       in_vld_i,
  input  logic [CH_NUM*DW-1:0]    in_data_i,
  input  logic                    clr_i,
  output logic [CH_NUM-1:0]       out_vld_o,
  output logic [CH_NUM*DW-1:0]    out_data_o,
  output logic [CH_NUM-1:0]       chg_o,
  output logic [CH_NUM*CNT_W-1:0] chg_cnt_o
);

  for (genvar ch = 0; ch < CH_NUM; ch++) begin : g_lane
    chnl_sample_lane #(
      .DW    (DW),
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
    ) u_lane (
      .clk        (clk),
      .rstn       (rstn),
      .en_i       (en_i[ch]),
      .in_vld_i   (in_vld_i[ch]),
      .in_data_i  (in_data_i[ch*DW +: DW]),
      .clr_i      (clr_i),
      .out_vld_o  (out_vld_o[ch]),
      .out_data_o (out_data_o[ch*DW +: DW]),
      .chg_o      (chg_o[ch]),
      .chg_cnt_o  (chg_cnt_o[ch*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_chnl_sample_pipe.sv
// Directed self-checking bench: 4-channel DEPTH=2 pipe plus a 1-channel
// DEPTH=1 instance with a 2-bit counter for saturation.
module tb_chnl_sample_pipe;

  logic        clk;
  logic        rstn;
  logic [3:0]  en;
  logic [3:0]  in_vld;
  logic [31:0] in_data;
  logic        clr;
  logic [3:0]  out_vld;
  logic [31:0] out_data;
  logic [3:0]  chg;
  logic [63:0] chg_cnt;

  logic        s_en;
  logic        s_vld;
  logic [7:0]  s_data;
  logic        s_clr;
  logic        s_out_vld;
  logic [7:0]  s_out_data;
  logic        s_chg;
  logic [1:0]  s_cnt;

  int n_chk;
  int n_err;

  chnl_sample_pipe #(.CH_NUM(4), .DW(8), .DEPTH(2), .CNT_W(16)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .en_i       (en),
    .in_vld_i   (in_vld),
    .in_data_i  (in_data),
    .clr_i      (clr),
    .out_vld_o  (out_vld),
    .out_data_o (out_data),
    .chg_o      (chg),
    .chg_cnt_o  (chg_cnt)
  );

  chnl_sample_pipe #(.CH_NUM(1), .DW(8), .DEPTH(1), .CNT_W(2)) dut_sat (
    .clk        (clk),
    .rstn       (rstn),
    .en_i       (s_en),
    .in_vld_i   (s_vld),
    .in_data_i  (s_data),
    .clr_i      (s_clr),
    .out_vld_o  (s_out_vld),
    .out_data_o (s_out_data),
    .chg_o      (s_chg),
    .chg_cnt_o  (s_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] seq2   [5];
    logic       chg2   [5];
    logic       en_t   [8];
    logic       v_t    [8];
    logic [7:0] d_t    [8];
    logic       ev_t   [8];
    logic [7:0] ed_t   [8];
    logic       ec_t   [8];
    logic [1:0] scnt_t [6];
    int         s_pulses;

    n_chk = 0;
    n_err = 0;
    rstn = 1'b0; en = 4'hF; in_vld = 4'h0; in_data = 32'h0; clr = 1'b0;
    s_en = 1'b1; s_vld = 1'b0; s_data = 8'h00; s_clr = 1'b0;

    // Reset state
    #1;
    chk("rst_vld",  {60'h0, out_vld},  64'h0);
    chk("rst_data", {32'h0, out_data}, 64'h0);
    chk("rst_chg",  {60'h0, chg},      64'h0);
    chk("rst_cnt",  chg_cnt,           64'h0);
    #11 rstn = 1'b1;
    cyc(); cyc();

    // Latency: ch0 item visible two edges after presentation, single pulse
    in_vld[0] = 1'b1; in_data[7:0] = 8'h11;
    cyc();
    chk("lat_early", {63'h0, out_vld[0]}, 64'h0);
    in_vld[0] = 1'b0;
    cyc();
    chk("lat_vld",  {63'h0, out_vld[0]},   64'h1);
    chk("lat_data", {56'h0, out_data[7:0]}, 64'h11);
    chk("lat_chg",  {63'h0, chg[0]},       64'h0);
    cyc();
    chk("lat_once", {63'h0, out_vld[0]}, 64'h0);

    // Change detect on ch1
    seq2 = '{8'h05, 8'h05, 8'h06, 8'h06, 8'h05};
    chg2 = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 6; k++) begin
      if (k < 5) begin
        in_vld[1] = 1'b1; in_data[15:8] = seq2[k];
      end else begin
        in_vld[1] = 1'b0;
      end
      cyc();
      if (k >= 1) begin
        chk($sformatf("chg_vld%0d", k-1),  {63'h0, out_vld[1]},     64'h1);
        chk($sformatf("chg_data%0d", k-1), {56'h0, out_data[15:8]}, {56'h0, seq2[k-1]});
        chk($sformatf("chg_pulse%0d", k-1), {63'h0, chg[1]},        {63'h0, chg2[k-1]});
      end
    end
    chk("chg_cnt1", {48'h0, chg_cnt[31:16]}, 64'd2);

    // Stall on ch2 for three cycles; ch3 keeps running
    en_t = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    v_t  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    d_t  = '{8'hA0, 8'hA1, 8'hA2, 8'hA2, 8'hA2, 8'hA2, 8'hA2, 8'hA2};
    ev_t = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    ed_t = '{8'h00, 8'hA0, 8'hA0, 8'hA0, 8'hA0, 8'hA1, 8'hA2, 8'hA2};
    ec_t = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int e = 0; e < 8; e++) begin
      en[2] = en_t[e]; in_vld[2] = v_t[e]; in_data[23:16] = d_t[e];
      in_vld[3] = (e == 2); in_data[31:24] = 8'h3C;
      cyc();
      chk($sformatf("stall_vld%0d", e),  {63'h0, out_vld[2]},      {63'h0, ev_t[e]});
      chk($sformatf("stall_data%0d", e), {56'h0, out_data[23:16]}, {56'h0, ed_t[e]});
      chk($sformatf("stall_chg%0d", e),  {63'h0, chg[2]},          {63'h0, ec_t[e]});
      if (e == 3) begin
        chk("stall_ch3_vld",  {63'h0, out_vld[3]},      64'h1);
        chk("stall_ch3_data", {56'h0, out_data[31:24]}, 64'h3C);
      end
    end
    in_vld[3] = 1'b0;
    chk("stall_cnt2", {48'h0, chg_cnt[47:32]}, 64'd2);

    // Clear colliding with a differing ch0 item leaving the pipe
    in_vld[0] = 1'b1; in_data[7:0] = 8'h22;
    cyc();
    in_vld[0] = 1'b0; clr = 1'b1;
    cyc();
    chk("clr_vld",  {63'h0, out_vld[0]},    64'h1);
    chk("clr_data", {56'h0, out_data[7:0]}, 64'h22);
    chk("clr_chg",  {63'h0, chg[0]},        64'h0);
    chk("clr_cnt",  chg_cnt,                64'h0);
    clr = 1'b0; in_vld[0] = 1'b1; in_data[7:0] = 8'h33;
    cyc();
    in_data[7:0] = 8'h44;
    cyc();
    chk("clr_first_chg", {63'h0, chg[0]}, 64'h0);
    chk("clr_first_cnt", chg_cnt,         64'h0);
    in_vld[0] = 1'b0;
    cyc();
    chk("clr_next_data", {56'h0, out_data[7:0]}, 64'h44);
    chk("clr_next_chg",  {63'h0, chg[0]},        64'h1);
    chk("clr_next_cnt",  chg_cnt,                64'h1);

    // Saturation on the 2-bit counter instance (DEPTH=1)
    scnt_t = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    s_pulses = 0;
    for (int k = 0; k < 6; k++) begin
      s_vld = 1'b1; s_data = (k % 2 == 1) ? 8'hFF : 8'h00;
      cyc();
      if (s_chg) s_pulses++;
      chk($sformatf("sat_vld%0d", k),  {63'h0, s_out_vld},  64'h1);
      chk($sformatf("sat_data%0d", k), {56'h0, s_out_data}, {56'h0, s_data});
      chk($sformatf("sat_cnt%0d", k),  {62'h0, s_cnt},      {62'h0, scnt_t[k]});
    end
    chk("sat_pulses", 64'(s_pulses), 64'd5);
    s_en = 1'b0; s_vld = 1'b1; s_data = 8'h00;
    cyc();
    chk("sat_stall_vld",  {63'h0, s_out_vld},  64'h0);
    chk("sat_stall_data", {56'h0, s_out_data}, 64'hFF);
    chk("sat_stall_chg",  {63'h0, s_chg},      64'h0);
    s_en = 1'b1; s_vld = 1'b0;

    // Async reset with items in flight
    in_vld = 4'hF; in_data = 32'h5A5A5A5A;
    cyc(); cyc();
    chk("pre_rst_vld", {60'h0, out_vld}, 64'hF);
    #2 rstn = 1'b0;
    #1;
    chk("arst_vld",  {60'h0, out_vld},  64'h0);
    chk("arst_data", {32'h0, out_data}, 64'h0);
    chk("arst_chg",  {60'h0, chg},      64'h0);
    chk("arst_cnt",  chg_cnt,           64'h0);
    chk("arst_sat",  {53'h0, s_out_vld, s_out_data, s_cnt}, 64'h0);
    in_vld = 4'h0;
    #2 rstn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk($sformatf("post_rst_vld%0d", k), {60'h0, out_vld}, 64'h0);
      chk($sformatf("post_rst_chg%0d", k), {60'h0, chg},     64'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
